// File: rtl/imuldiv_int_div_iterative_pkg.sv
// Shared definitions for the iterative divider: function codes, FSM encodings,
// mux selects and the control bundle passed from ctrl to dpath.
package imuldiv_int_div_iterative_pkg;

    localparam logic DIV_FN_UNSIGNED = 1'b0;
    localparam logic DIV_FN_SIGNED   = 1'b1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_SIGN = 2'd2;

    localparam logic op_load = 1'b0;
    localparam logic op_next = 1'b1;

    typedef struct packed {
        logic rq_en;
        logic rq_sel;
        logic sub_sel;
        logic cntr_en;
        logic cntr_sel;
        logic sign_en;
    } div_ctrl_t;

endpackage

// File: rtl/imuldiv_int_div_iterative_ctrl.sv
// Divider control: IDLE/CALC/SIGN sequencing, control-signal table and
// val/rdy handshakes.
module imuldiv_int_div_iterative_ctrl
    import imuldiv_int_div_iterative_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      divreq_val,
    output logic      divreq_rdy,
    output logic      divresp_val,
    input  logic      divresp_rdy,
    input  logic      cntr_zero,
    input  logic      sub_neg,
    output div_ctrl_t ctrl
);

    logic [1:0] state;
    logic [1:0] state_next;
    logic       req_fire;
    logic       resp_fire;

    // Handshakes are masked during reset so nothing is offered or accepted
    assign divreq_rdy  = !reset && (state == ST_IDLE);
    assign divresp_val = !reset && (state == ST_SIGN);
    assign req_fire    = divreq_val && divreq_rdy;
    assign resp_fire   = divresp_val && divresp_rdy;

    always_ff @(posedge clk) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (req_fire)  state_next = ST_CALC;
            ST_CALC: if (cntr_zero) state_next = ST_SIGN;
            ST_SIGN: if (resp_fire) state_next = ST_IDLE;
            default:                state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        ctrl = '0;
        case (state)
            ST_IDLE: begin
                if (req_fire) begin
                    ctrl.sign_en  = 1'b1;
                    ctrl.rq_en    = 1'b1;
                    ctrl.rq_sel   = op_load;
                    ctrl.cntr_en  = 1'b1;
                    ctrl.cntr_sel = op_load;
                end
            end
            ST_CALC: begin
                ctrl.rq_en    = 1'b1;
                ctrl.rq_sel   = op_next;
                ctrl.sub_sel  = !sub_neg;
                ctrl.cntr_en  = 1'b1;
                ctrl.cntr_sel = op_next;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/imuldiv_int_div_iterative_dpath.sv
// Divider datapath: magnitude/sign capture, 33-bit restoring subtractor,
// step counter and output sign correction.
module imuldiv_int_div_iterative_dpath
    import imuldiv_int_div_iterative_pkg::*;
#(
    parameter int NBITS     = 32,
    parameter int CNTR_BITS = $clog2(NBITS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               fn,
    input  logic [NBITS-1:0]   a,
    input  logic [NBITS-1:0]   b,
    input  div_ctrl_t          ctrl,
    output logic               cntr_zero,
    output logic               sub_neg,
    output logic [2*NBITS-1:0] result
);

    localparam logic [CNTR_BITS-1:0] CNTR_INIT = CNTR_BITS'(NBITS - 1);

    logic [NBITS-1:0]     a_mag;
    logic [NBITS-1:0]     b_mag_in;
    logic [NBITS-1:0]     b_mag;
    logic [2*NBITS-1:0]   rem_quot;
    logic [2*NBITS:0]     shifted;
    logic [NBITS:0]       diff;
    logic [CNTR_BITS-1:0] cntr;
    logic                 rem_sign;
    logic                 quot_sign;
    logic [NBITS-1:0]     q_raw;
    logic [NBITS-1:0]     r_raw;
    logic [NBITS-1:0]     q_out;
    logic [NBITS-1:0]     r_out;

    assign a_mag     = (fn == DIV_FN_SIGNED && a[NBITS-1]) ? -a : a;
    assign b_mag_in  = (fn == DIV_FN_SIGNED && b[NBITS-1]) ? -b : b;
    assign shifted   = {rem_quot, 1'b0};
    assign diff      = shifted[2*NBITS:NBITS] - {1'b0, b_mag};
    assign sub_neg   = diff[NBITS];
    assign cntr_zero = (cntr == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            b_mag     <= '0;
            rem_sign  <= 1'b0;
            quot_sign <= 1'b0;
            rem_quot  <= '0;
            cntr      <= '0;
        end else begin
            if (ctrl.sign_en) begin
                b_mag     <= b_mag_in;
                rem_sign  <= fn & a[NBITS-1];
                quot_sign <= fn & (a[NBITS-1] ^ b[NBITS-1]) & (b != '0);
            end
            // A successful subtract commits the difference and shifts a 1 into the quotient
            if (ctrl.rq_en) begin
                if (ctrl.rq_sel == op_load)
                    rem_quot <= {{NBITS{1'b0}}, a_mag};
                else if (ctrl.sub_sel)
                    rem_quot <= {diff[NBITS-1:0], rem_quot[NBITS-2:0], 1'b1};
                else
                    rem_quot <= {shifted[2*NBITS-1:NBITS], rem_quot[NBITS-2:0], 1'b0};
            end
            if (ctrl.cntr_en) begin
                if (ctrl.cntr_sel == op_load)
                    cntr <= CNTR_INIT;
                else
                    cntr <= cntr - 1'b1;
            end
        end
    end

    assign q_raw  = rem_quot[NBITS-1:0];
    assign r_raw  = rem_quot[2*NBITS-1:NBITS];
    assign q_out  = quot_sign ? -q_raw : q_raw;
    assign r_out  = rem_sign ? -r_raw : r_raw;
    assign result = {r_out, q_out};

endmodule

// File: rtl/imuldiv_int_div_iterative.sv
// Iterative 32-bit divide/remainder unit: restoring shift-subtract on
// magnitudes, sign-corrected result on a val/rdy response port.
module imuldiv_int_div_iterative
    import imuldiv_int_div_iterative_pkg::*;
#(
    parameter int NBITS     = 32,
    parameter int CNTR_BITS = $clog2(NBITS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               divreq_msg_fn,
    input  logic [NBITS-1:0]   divreq_msg_a,
    input  logic [NBITS-1:0]   divreq_msg_b,
    input  logic               divreq_val,
    output logic               divreq_rdy,
    output logic [2*NBITS-1:0] divresp_msg_result,
    output logic               divresp_val,
    input  logic               divresp_rdy
);

    div_ctrl_t ctrl;
    logic      cntr_zero;
    logic      sub_neg;

    imuldiv_int_div_iterative_ctrl u_ctrl (
        .clk         (clk),
        .reset       (reset),
        .divreq_val  (divreq_val),
        .divreq_rdy  (divreq_rdy),
        .divresp_val (divresp_val),
        .divresp_rdy (divresp_rdy),
        .cntr_zero   (cntr_zero),
        .sub_neg     (sub_neg),
        .ctrl        (ctrl)
    );

    imuldiv_int_div_iterative_dpath #(
        .NBITS     (NBITS),
        .CNTR_BITS (CNTR_BITS)
    ) u_dpath (
        .clk       (clk),
        .reset     (reset),
        .fn        (divreq_msg_fn),
        .a         (divreq_msg_a),
        .b         (divreq_msg_b),
        .ctrl      (ctrl),
        .cntr_zero (cntr_zero),
        .sub_neg   (sub_neg),
        .result    (divresp_msg_result)
    );

endmodule

// File: tb/tb_imuldiv_int_div_iterative.sv
// Self-checking bench for the iterative divider: directed vector table, corner
// sequences (backpressure, reset mid-op) and random operands against a reference model.
module tb_imuldiv_int_div_iterative;

    logic        clk;
    logic        reset;
    logic        divreq_msg_fn;
    logic [31:0] divreq_msg_a;
    logic [31:0] divreq_msg_b;
    logic        divreq_val;
    logic        divreq_rdy;
    logic [63:0] divresp_msg_result;
    logic        divresp_val;
    logic        divresp_rdy;

    int assertions = 0;
    int failures   = 0;

    imuldiv_int_div_iterative dut (
        .clk                (clk),
        .reset              (reset),
        .divreq_msg_fn      (divreq_msg_fn),
        .divreq_msg_a       (divreq_msg_a),
        .divreq_msg_b       (divreq_msg_b),
        .divreq_val         (divreq_val),
        .divreq_rdy         (divreq_rdy),
        .divresp_msg_result (divresp_msg_result),
        .divresp_val        (divresp_val),
        .divresp_rdy        (divresp_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        fn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[11];

    // RISC-V M semantics from plain arithmetic: truncating division, remainder follows dividend
    function automatic logic [63:0] refModel(input logic fn, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        int sa;
        int sb;
        if (b == 32'd0) begin
            q = 32'hFFFFFFFF;
            r = a;
        end else if (!fn) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
            q = 32'h80000000;
            r = 32'd0;
        end else begin
            sa = $signed(a);
            sb = $signed(b);
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end
        return {r, q};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        assertions++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, actual, expected);
        end
    endtask

    // Issue one request from a negedge and wait for its response; returns at the negedge after the response fire
    task automatic applyStimulus(input logic fn, input logic [31:0] a, input logic [31:0] b,
                                 output logic [63:0] res, output int lat, output bit timed_out);
        int waits;
        timed_out     = 1'b0;
        lat           = 0;
        res           = '0;
        divreq_msg_fn = fn;
        divreq_msg_a  = a;
        divreq_msg_b  = b;
        divreq_val    = 1'b1;
        divresp_rdy   = 1'b1;
        waits = 0;
        while (!divreq_rdy && waits < 100) begin
            @(negedge clk);
            waits++;
        end
        if (!divreq_rdy) begin
            timed_out  = 1'b1;
            divreq_val = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        divreq_val = 1'b0;
        lat = 1;
        while (!divresp_val && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (!divresp_val) begin
            timed_out = 1'b1;
            return;
        end
        res = divresp_msg_result;
        @(negedge clk);
    endtask

    initial begin
        logic [63:0] res;
        logic [63:0] exp;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rfn;
        int          lat;
        bit          to;
        bit          seen_val;

        vecs[0]  = '{1'b0, 32'd20,         32'd3,          64'h00000002_00000006};
        vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,          64'hFFFFFFFF_FFFFFFFD};
        vecs[2]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   64'h00000001_FFFFFFFD};
        vecs[3]  = '{1'b0, 32'd5,          32'd0,          64'h00000005_FFFFFFFF};
        vecs[4]  = '{1'b1, 32'hFFFFFFFB,   32'd0,          64'hFFFFFFFB_FFFFFFFF};
        vecs[5]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000};
        vecs[6]  = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   64'h80000000_00000000};
        vecs[7]  = '{1'b0, 32'd100,        32'd7,          64'h00000002_0000000E};
        vecs[8]  = '{1'b0, 32'hFFFFFFFF,   32'd1,          64'h00000000_FFFFFFFF};
        vecs[9]  = '{1'b1, 32'hFFFFFFFF,   32'hFFFFFFFF,   64'h00000000_00000001};
        vecs[10] = '{1'b0, 32'd3,          32'd5,          64'h00000003_00000000};

        reset         = 1'b1;
        divreq_msg_fn = 1'b0;
        divreq_msg_a  = '0;
        divreq_msg_b  = '0;
        divreq_val    = 1'b0;
        divresp_rdy   = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_req_rdy", {63'd0, divreq_rdy}, 64'd0);
        checkOutput("reset_resp_val", {63'd0, divresp_val}, 64'd0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("post_reset_req_rdy", {63'd0, divreq_rdy}, 64'd1);
        checkOutput("post_reset_resp_val", {63'd0, divresp_val}, 64'd0);

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].fn, vecs[i].a, vecs[i].b, res, lat, to);
            checkOutput($sformatf("vec%0d_timeout", i), {63'd0, to}, 64'd0);
            checkOutput($sformatf("vec%0d_result", i), res, vecs[i].exp);
            checkOutput($sformatf("vec%0d_latency", i), 64'(lat), 64'd33);
        end

        // Backpressure: response held for 10 cycles while a new request stays asserted
        exp           = 64'h00000001_0000006F;
        divresp_rdy   = 1'b0;
        divreq_msg_fn = 1'b0;
        divreq_msg_a  = 32'd1000;
        divreq_msg_b  = 32'd9;
        divreq_val    = 1'b1;
        checkOutput("bp_req_rdy_idle", {63'd0, divreq_rdy}, 64'd1);
        @(posedge clk);
        @(negedge clk);
        divreq_msg_a = 32'd5;
        divreq_msg_b = 32'd1;
        lat = 1;
        while (!divresp_val && lat < 100) begin
            checkOutput("bp_req_rdy_calc", {63'd0, divreq_rdy}, 64'd0);
            @(negedge clk);
            lat++;
        end
        checkOutput("bp_latency", 64'(lat), 64'd33);
        for (int k = 0; k < 10; k++) begin
            checkOutput($sformatf("bp_val_%0d", k), {63'd0, divresp_val}, 64'd1);
            checkOutput($sformatf("bp_result_%0d", k), divresp_msg_result, exp);
            checkOutput($sformatf("bp_req_rdy_%0d", k), {63'd0, divreq_rdy}, 64'd0);
            @(negedge clk);
        end
        divresp_rdy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("bp_after_fire_val", {63'd0, divresp_val}, 64'd0);
        checkOutput("bp_after_fire_req_rdy", {63'd0, divreq_rdy}, 64'd1);
        divreq_val = 1'b0;
        @(negedge clk);

        // Reset 10 cycles into CALC aborts the operation
        divreq_msg_fn = 1'b0;
        divreq_msg_a  = 32'd50;
        divreq_msg_b  = 32'd3;
        divreq_val    = 1'b1;
        checkOutput("abort_req_rdy", {63'd0, divreq_rdy}, 64'd1);
        @(posedge clk);
        @(negedge clk);
        divreq_val = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("abort_reset_req_rdy", {63'd0, divreq_rdy}, 64'd0);
        checkOutput("abort_reset_resp_val", {63'd0, divresp_val}, 64'd0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("abort_post_req_rdy", {63'd0, divreq_rdy}, 64'd1);
        seen_val = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (divresp_val) seen_val = 1'b1;
            @(negedge clk);
        end
        checkOutput("abort_no_stale_val", {63'd0, seen_val}, 64'd0);
        applyStimulus(1'b0, 32'd100, 32'd7, res, lat, to);
        checkOutput("abort_next_timeout", {63'd0, to}, 64'd0);
        checkOutput("abort_next_result", res, 64'h00000002_0000000E);

        // Random operands, biased toward zero, -1, small divisors and the most negative dividend
        for (int i = 0; i < 40; i++) begin
            rfn = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFFFFFF;
                2:       rb = 32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            ra = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            applyStimulus(rfn, ra, rb, res, lat, to);
            checkOutput($sformatf("rand%0d_timeout", i), {63'd0, to}, 64'd0);
            checkOutput($sformatf("rand%0d_fn%0d_a%h_b%h", i, rfn, ra, rb), res, refModel(rfn, ra, rb));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
